// File: rtl/dc_qbus_mst.sv
// Q-bus master cycle sequencer: runs DATI/DATO/DATOB with SYNC/DIN/DOUT/WTBT/BS7.
// Define QBUS_TIMEOUT_EN to build the no-reply bus timeout (abt_nxm).
module dc_qbus_mst #(
  parameter int unsigned TMO_TICKS = 64
) (
  input  logic        pin_clk,
  input  logic        sr_rst,
  input  logic        pin_mce_p,
  input  logic        pin_mce_n,
  input  logic        req,
  input  logic        req_wr,
  input  logic        req_byte,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic        pin_m15,
  input  logic        pin_bso,
  input  logic        pin_ra_n,
  input  logic        pin_de_n,
  input  logic        rply_n,
  input  logic [15:0] pin_adi,
  output logic [15:0] pin_ado,
  output logic        sync,
  output logic        din,
  output logic        dout,
  output logic        wtbt,
  output logic        bs7,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic        abt_mmu,
  output logic        abt_nxm,
  output logic        abt_odd
);

  localparam int unsigned DW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_SYNC,
    S_DATA,
    S_END,
    S_ABORT
  } state_e;

  state_e        state_q;
  logic          wr_q, byte_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] ado_q, rdata_q;
  logic          sync_q, din_q, dout_q, wtbt_q, bs7_q;
  logic          busy_q, done_q;
  logic          abt_mmu_q, abt_nxm_q, abt_odd_q;

  logic reply_c;
  logic bs7_c;
  logic tmo_hit_c;

  assign reply_c = !rply_n || !pin_ra_n;
  // With translation active the MMU decides the I/O page; otherwise it is the top 8 KB.
  assign bs7_c   = !pin_m15 ? pin_bso : (req_addr[15:13] == 3'b111);

`ifdef QBUS_TIMEOUT_EN
  localparam int unsigned TW = (TMO_TICKS > 1) ? $clog2(TMO_TICKS) : 1;

  logic [TW-1:0] tmo_q;

  assign tmo_hit_c = (32'(tmo_q) == TMO_TICKS - 32'd1);

  // Counts DATA ticks without a reply; cleared while entering DATA.
  always_ff @(posedge pin_clk or posedge sr_rst) begin
    if (sr_rst) begin
      tmo_q <= '0;
    end else if (pin_mce_p) begin
      if (state_q == S_SYNC) begin
        tmo_q <= '0;
      end else if (state_q == S_DATA && !tmo_hit_c) begin
        tmo_q <= tmo_q + TW'(1);
      end
    end
  end
`else
  // Timeout not built: DATA waits for a reply forever.
  assign tmo_hit_c = (TMO_TICKS == 32'd0) & 1'b0;
`endif

  always_ff @(posedge pin_clk or posedge sr_rst) begin
    if (sr_rst) begin
      state_q   <= S_IDLE;
      wr_q      <= 1'b0;
      byte_q    <= 1'b0;
      wdata_q   <= '0;
      ado_q     <= '0;
      sync_q    <= 1'b0;
      din_q     <= 1'b0;
      dout_q    <= 1'b0;
      wtbt_q    <= 1'b0;
      bs7_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abt_mmu_q <= 1'b0;
      abt_nxm_q <= 1'b0;
      abt_odd_q <= 1'b0;
    end else if (pin_mce_p) begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            wr_q      <= req_wr;
            byte_q    <= req_byte;
            wdata_q   <= req_wdata;
            busy_q    <= 1'b1;
            abt_mmu_q <= 1'b0;
            abt_nxm_q <= 1'b0;
            if (!req_byte && req_addr[0]) begin
              state_q   <= S_ABORT;
              abt_odd_q <= 1'b1;
              done_q    <= 1'b1;
            end else begin
              state_q   <= S_ADDR;
              abt_odd_q <= 1'b0;
              ado_q     <= req_addr;
              wtbt_q    <= req_wr;
              bs7_q     <= bs7_c;
            end
          end
        end
        S_ADDR: begin
          state_q <= S_SYNC;
          sync_q  <= 1'b1;
        end
        S_SYNC: begin
          if (!pin_de_n) begin
            state_q   <= S_ABORT;
            abt_mmu_q <= 1'b1;
            done_q    <= 1'b1;
            sync_q    <= 1'b0;
            wtbt_q    <= 1'b0;
            bs7_q     <= 1'b0;
            ado_q     <= '0;
          end else begin
            state_q <= S_DATA;
            if (wr_q) begin
              dout_q <= 1'b1;
              ado_q  <= wdata_q;
              wtbt_q <= byte_q;
            end else begin
              din_q  <= 1'b1;
              ado_q  <= '0;
              wtbt_q <= 1'b0;
            end
          end
        end
        S_DATA: begin
          // A reply beats a timeout seen on the same tick.
          if (reply_c) begin
            state_q <= S_END;
            done_q  <= 1'b1;
            din_q   <= 1'b0;
            dout_q  <= 1'b0;
            wtbt_q  <= 1'b0;
            bs7_q   <= 1'b0;
            ado_q   <= '0;
          end else if (tmo_hit_c) begin
            state_q   <= S_ABORT;
            abt_nxm_q <= 1'b1;
            done_q    <= 1'b1;
            sync_q    <= 1'b0;
            din_q     <= 1'b0;
            dout_q    <= 1'b0;
            wtbt_q    <= 1'b0;
            bs7_q     <= 1'b0;
            ado_q     <= '0;
          end
        end
        S_END: begin
          if (rply_n && pin_ra_n) begin
            state_q <= S_IDLE;
            sync_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        S_ABORT: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          sync_q  <= 1'b0;
          din_q   <= 1'b0;
          dout_q  <= 1'b0;
          wtbt_q  <= 1'b0;
          bs7_q   <= 1'b0;
          busy_q  <= 1'b0;
          ado_q   <= '0;
        end
      endcase
    end
  end

  // Read data is taken on the falling-edge enable while the reply is present in DATA.
  always_ff @(posedge pin_clk or posedge sr_rst) begin
    if (sr_rst) begin
      rdata_q <= '0;
    end else if (pin_mce_n && state_q == S_DATA && !wr_q && reply_c) begin
      rdata_q <= pin_adi;
    end
  end

  assign pin_ado = ado_q;
  assign sync    = sync_q;
  assign din     = din_q;
  assign dout    = dout_q;
  assign wtbt    = wtbt_q;
  assign bs7     = bs7_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign abt_mmu = abt_mmu_q;
  assign abt_nxm = abt_nxm_q;
  assign abt_odd = abt_odd_q;

endmodule

// File: tb/tb_dc_qbus_mst.sv
// Self-checking bench for dc_qbus_mst: per-scenario tasks, completion scoreboard.
`timescale 1ns/1ps
module tb_dc_qbus_mst;

  localparam int unsigned TMO = 64;

  logic        pin_clk = 1'b0;
  logic        sr_rst;
  logic [1:0]  phase = 2'd0;
  logic        pin_mce_p, pin_mce_n;
  logic        req, req_wr, req_byte;
  logic [15:0] req_addr, req_wdata;
  logic        pin_m15, pin_bso, pin_ra_n, pin_de_n, rply_n;
  logic [15:0] pin_adi;
  logic [15:0] pin_ado, rdata;
  logic        sync, din, dout, wtbt, bs7, busy, done;
  logic        abt_mmu, abt_nxm, abt_odd;
  logic [41:0] all_o;

  typedef struct {
    logic [15:0] rdata;
    logic [2:0]  abt;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_rdata = 16'h0;

  dc_qbus_mst #(.TMO_TICKS(TMO)) dut (
    .pin_clk(pin_clk), .sr_rst(sr_rst), .pin_mce_p(pin_mce_p), .pin_mce_n(pin_mce_n),
    .req(req), .req_wr(req_wr), .req_byte(req_byte), .req_addr(req_addr),
    .req_wdata(req_wdata), .pin_m15(pin_m15), .pin_bso(pin_bso), .pin_ra_n(pin_ra_n),
    .pin_de_n(pin_de_n), .rply_n(rply_n), .pin_adi(pin_adi), .pin_ado(pin_ado),
    .sync(sync), .din(din), .dout(dout), .wtbt(wtbt), .bs7(bs7), .busy(busy),
    .done(done), .rdata(rdata), .abt_mmu(abt_mmu), .abt_nxm(abt_nxm), .abt_odd(abt_odd)
  );

  always #5 pin_clk = ~pin_clk;
  always @(negedge pin_clk) phase <= phase + 2'd1;
  assign pin_mce_n = (phase == 2'd1);
  assign pin_mce_p = (phase == 2'd3);
  assign all_o = {pin_ado, sync, din, dout, wtbt, bs7, busy, done, rdata, abt_mmu, abt_nxm, abt_odd};

  // One mce_p tick; returns 1 ns after the active edge.
  task automatic tick();
    do @(posedge pin_clk); while (pin_mce_p !== 1'b1);
    #1;
  endtask

  task automatic issue(input logic wr, input logic bt, input logic [15:0] a, input logic [15:0] wd);
    req = 1'b1; req_wr = wr; req_byte = bt; req_addr = a; req_wdata = wd;
    tick();
    req = 1'b0;
  endtask

  task automatic test_reset();
    sr_rst = 1'b1;
    tick(); tick();
    checks++;
    if (all_o !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h required 0", all_o);
    end
    sr_rst = 1'b0;
    tick();
    checks++;
    if (all_o !== '0) begin
      errors++; $display("FAIL reset_idle: got %h required 0", all_o);
    end
  endtask

  task automatic test_read_rply();
    int n; int din_ticks; exp_t e;
    exp_q.push_back('{rdata: 16'o123456, abt: 3'b000, lat: 6});
    model_rdata = 16'o123456;
    issue(1'b0, 1'b0, 16'o001000, 16'h0); n = 1;
    checks++;
    if ({pin_ado, wtbt, bs7, sync, busy} !== {16'o001000, 4'b0001}) begin
      errors++; $display("FAIL rd_addr_phase: got %o/%b%b%b%b required 001000/0001", pin_ado, wtbt, bs7, sync, busy);
    end
    din_ticks = 0;
    while (done !== 1'b1 && n < 20) begin
      if (n == 5) begin rply_n = 1'b0; pin_adi = 16'o123456; end
      tick(); n++;
      if (din === 1'b1) din_ticks++;
      if (n == 3) begin
        checks++;
        if ({sync, din, dout, pin_ado} !== {3'b110, 16'h0}) begin
          errors++; $display("FAIL rd_data_phase: got sync=%b din=%b dout=%b ado=%o required 1 1 0 0", sync, din, dout, pin_ado);
        end
      end
    end
    e = exp_q.pop_front();
    checks++;
    if (n != e.lat || {rdata, abt_mmu, abt_nxm, abt_odd} !== {e.rdata, e.abt}) begin
      errors++; $display("FAIL rd_rply_txn: got lat=%0d rdata=%o abt=%b required lat=%0d rdata=%o abt=%b",
                         n, rdata, {abt_mmu, abt_nxm, abt_odd}, e.lat, e.rdata, e.abt);
    end
    checks++;
    if (din_ticks != 3 || din !== 1'b0 || sync !== 1'b1) begin
      errors++; $display("FAIL rd_din_pulse: got din_ticks=%0d din=%b sync=%b required 3 0 1", din_ticks, din, sync);
    end
    rply_n = 1'b1;
    tick();
    checks++;
    if ({sync, busy, done} !== 3'b000) begin
      errors++; $display("FAIL rd_end_release: got sync=%b busy=%b done=%b required 0 0 0", sync, busy, done);
    end
  endtask

  task automatic test_byte_write();
    exp_t e;
    exp_q.push_back('{rdata: model_rdata, abt: 3'b000, lat: 4});
    pin_adi = 16'o070707;
    issue(1'b1, 1'b1, 16'o001001, 16'o000377);
    checks++;
    if ({pin_ado, wtbt} !== {16'o001001, 1'b1}) begin
      errors++; $display("FAIL wr_addr_phase: got ado=%o wtbt=%b required 001001 1", pin_ado, wtbt);
    end
    tick(); tick();
    checks++;
    if ({dout, din, wtbt, sync, pin_ado} !== {4'b1011, 16'o000377}) begin
      errors++; $display("FAIL wr_data_phase: got dout=%b din=%b wtbt=%b sync=%b ado=%o required 1 0 1 1 377",
                         dout, din, wtbt, sync, pin_ado);
    end
    req = 1'b1; req_wr = 1'b0; req_byte = 1'b0; req_addr = 16'o000776; rply_n = 1'b0;
    tick();
    req = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (done !== 1'b1 || dout !== 1'b0 || {rdata, abt_mmu, abt_nxm, abt_odd} !== {e.rdata, e.abt}) begin
      errors++; $display("FAIL wr_txn: got done=%b dout=%b rdata=%o abt=%b required 1 0 %o %b",
                         done, dout, rdata, {abt_mmu, abt_nxm, abt_odd}, e.rdata, e.abt);
    end
    rply_n = 1'b1;
    tick(); tick();
    checks++;
    if ({busy, sync, pin_ado} !== {2'b00, 16'h0}) begin
      errors++; $display("FAIL wr_req_ignored: got busy=%b sync=%b ado=%o required 0 0 0", busy, sync, pin_ado);
    end
  endtask

  task automatic test_bs7_ra_reply();
    logic        tm15 [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic        tbso [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] ta   [4] = '{16'o177572, 16'o177572, 16'o160000, 16'o157776};
    logic        tbs7 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int n; exp_t e; logic [15:0] d;
    for (int k = 0; k < 4; k++) begin
      pin_m15 = tm15[k]; pin_bso = tbso[k];
      d = 16'($urandom);
      exp_q.push_back('{rdata: d, abt: 3'b000, lat: 4});
      model_rdata = d;
      issue(1'b0, 1'b0, ta[k], 16'h0); n = 1;
      checks++;
      if (bs7 !== tbs7[k]) begin
        errors++; $display("FAIL bs7_case%0d: got %b required %b", k, bs7, tbs7[k]);
      end
      while (done !== 1'b1 && n < 20) begin
        if (n == 3) begin pin_ra_n = 1'b0; pin_adi = d; end
        tick(); n++;
      end
      e = exp_q.pop_front();
      checks++;
      if (n != e.lat || {rdata, abt_mmu, abt_nxm, abt_odd} !== {e.rdata, e.abt}) begin
        errors++; $display("FAIL ra_txn%0d: got lat=%0d rdata=%o abt=%b required lat=%0d rdata=%o abt=%b",
                           k, n, rdata, {abt_mmu, abt_nxm, abt_odd}, e.lat, e.rdata, e.abt);
      end
      pin_ra_n = 1'b1; pin_m15 = 1'b1; pin_bso = 1'b0;
      tick();
    end
  endtask

  task automatic test_mmu_abort();
    exp_t e;
    exp_q.push_back('{rdata: model_rdata, abt: 3'b100, lat: 3});
    issue(1'b0, 1'b0, 16'o002000, 16'h0);
    pin_de_n = 1'b0; rply_n = 1'b0; pin_adi = 16'o031313;
    tick();
    checks++;
    if ({sync, din} !== 2'b10) begin
      errors++; $display("FAIL mmu_sync_phase: got sync=%b din=%b required 1 0", sync, din);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({done, sync, din, dout} !== 4'b1000 || {rdata, abt_mmu, abt_nxm, abt_odd} !== {e.rdata, e.abt}) begin
      errors++; $display("FAIL mmu_abort: got done=%b sync=%b din=%b dout=%b rdata=%o abt=%b required 1 0 0 0 %o %b",
                         done, sync, din, dout, rdata, {abt_mmu, abt_nxm, abt_odd}, e.rdata, e.abt);
    end
    pin_de_n = 1'b1; rply_n = 1'b1;
    tick();
    checks++;
    if ({done, busy, abt_mmu} !== 3'b001) begin
      errors++; $display("FAIL mmu_after: got done=%b busy=%b abt_mmu=%b required 0 0 1", done, busy, abt_mmu);
    end
  endtask

  task automatic test_timeout();
    int n; exp_t e;
    pin_adi = 16'o111111;
    issue(1'b0, 1'b0, 16'o003000, 16'h0); n = 1;
`ifdef QBUS_TIMEOUT_EN
    exp_q.push_back('{rdata: model_rdata, abt: 3'b010, lat: 3 + int'(TMO)});
    while (done !== 1'b1 && n < 3 + int'(TMO) + 20) begin tick(); n++; end
    e = exp_q.pop_front();
    checks++;
    if (n != e.lat || {rdata, abt_mmu, abt_nxm, abt_odd} !== {e.rdata, e.abt} || {sync, din} !== 2'b00) begin
      errors++; $display("FAIL timeout_txn: got lat=%0d rdata=%o abt=%b sync=%b din=%b required lat=%0d %o %b 0 0",
                         n, rdata, {abt_mmu, abt_nxm, abt_odd}, sync, din, e.lat, e.rdata, e.abt);
    end
    tick();
    checks++;
    if ({busy, done, abt_nxm} !== 3'b001) begin
      errors++; $display("FAIL timeout_after: got busy=%b done=%b abt_nxm=%b required 0 0 1", busy, done, abt_nxm);
    end
`else
    begin
      int seen_done = 0;
      for (int i = 0; i < 100; i++) begin
        tick(); n++;
        if (done === 1'b1) seen_done++;
      end
      checks++;
      if ({busy, sync, din} !== 3'b111 || seen_done != 0) begin
        errors++; $display("FAIL no_timeout_wait: got busy=%b sync=%b din=%b dones=%0d required 1 1 1 0",
                           busy, sync, din, seen_done);
      end
    end
    exp_q.push_back('{rdata: 16'o000111, abt: 3'b000, lat: n + 1});
    model_rdata = 16'o000111;
    rply_n = 1'b0; pin_adi = 16'o000111;
    tick(); n++;
    e = exp_q.pop_front();
    checks++;
    if (done !== 1'b1 || n != e.lat || {rdata, abt_mmu, abt_nxm, abt_odd} !== {e.rdata, e.abt}) begin
      errors++; $display("FAIL late_rply_txn: got done=%b lat=%0d rdata=%o abt=%b required 1 %0d %o %b",
                         done, n, rdata, {abt_mmu, abt_nxm, abt_odd}, e.lat, e.rdata, e.abt);
    end
    rply_n = 1'b1;
    tick();
`endif
  endtask

  task automatic test_odd_and_reset();
    exp_t e;
    exp_q.push_back('{rdata: model_rdata, abt: 3'b001, lat: 1});
    issue(1'b1, 1'b0, 16'o000003, 16'o001234);
    e = exp_q.pop_front();
    checks++;
    if ({done, busy, sync, dout} !== 4'b1100 || {rdata, abt_mmu, abt_nxm, abt_odd} !== {e.rdata, e.abt}) begin
      errors++; $display("FAIL odd_abort: got done=%b busy=%b sync=%b dout=%b rdata=%o abt=%b required 1 1 0 0 %o %b",
                         done, busy, sync, dout, rdata, {abt_mmu, abt_nxm, abt_odd}, e.rdata, e.abt);
    end
    tick();
    checks++;
    if ({done, busy, sync, abt_odd} !== 4'b0001) begin
      errors++; $display("FAIL odd_after: got done=%b busy=%b sync=%b abt_odd=%b required 0 0 0 1", done, busy, sync, abt_odd);
    end
    issue(1'b0, 1'b0, 16'o004000, 16'h0);
    checks++;
    if ({abt_odd, busy} !== 2'b01) begin
      errors++; $display("FAIL abt_clear_on_req: got abt_odd=%b busy=%b required 0 1", abt_odd, busy);
    end
    tick();
    #2 sr_rst = 1'b1;
    #1;
    checks++;
    if (all_o !== '0) begin
      errors++; $display("FAIL async_reset: got %h required 0", all_o);
    end
    sr_rst = 1'b0;
    model_rdata = 16'h0;
    tick(); tick();
    checks++;
    if ({busy, done, sync, rdata} !== {3'b000, model_rdata}) begin
      errors++; $display("FAIL post_reset_idle: got busy=%b done=%b sync=%b rdata=%o required 0 0 0 %o",
                         busy, done, sync, rdata, model_rdata);
    end
  endtask

  initial begin
    sr_rst = 1'b1; req = 1'b0; req_wr = 1'b0; req_byte = 1'b0;
    req_addr = 16'h0; req_wdata = 16'h0;
    pin_m15 = 1'b1; pin_bso = 1'b0; pin_ra_n = 1'b1; pin_de_n = 1'b1; rply_n = 1'b1;
    pin_adi = 16'h0;
    test_reset();
    test_read_rply();
    test_byte_write();
    test_bs7_ra_reply();
    test_mmu_abort();
    test_timeout();
    test_odd_and_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
